// File: rtl/volt_pkg.sv
// volt_pkg: shared constants, FSM encoding and channel-pick helper for the voltage calibration sequencer
package volt_pkg;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;
  localparam int DEC_W = 20;
  localparam int FULL_SCALE = 50000;
  localparam int SHIFT = 15;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [7:0] ASCII_PLUS = 8'd43;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  typedef enum logic [2:0] {S_IDLE, S_MAG, S_MUL, S_SCALE, S_CONV, S_STORE} state_t;
  function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_CH-1:0] m);
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) low_idx = IDX_W'(i);
  endfunction
endpackage

// File: rtl/bcd_serial.sv
// bcd_serial: serial double-dabble binary to 5-digit BCD converter, done 17 cycles after start
module bcd_serial
  import volt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic [DEC_W-1:0]  dec_o,
  output logic              done_o
);
  logic [DATA_W-1:0] sr_q;
  logic [DEC_W-1:0] acc_q, dec_q, adj, acc_d;
  logic [3:0] cnt_q;
  logic run_q, done_q;
  // add 3 to every digit >= 5, then shift in the next binary bit
  always_comb begin
    adj = '0;
    for (int i = 0; i < DEC_W / 4; i++) adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    acc_d = {adj[DEC_W-2:0], sr_q[DATA_W-1]};
  end
  // load on start, 16 iterations, final iteration writes the output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      sr_q <= '0;
      acc_q <= '0;
      dec_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!run_q) begin
        if (start_i) begin
          run_q <= 1'b1;
          sr_q <= bin_i;
          acc_q <= '0;
          cnt_q <= '0;
        end
      end else begin
        sr_q <= sr_q << 1;
        acc_q <= acc_d;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          run_q <= 1'b0;
          dec_q <= acc_d;
          done_q <= 1'b1;
        end
      end
    end
  assign dec_o = dec_q;
  assign done_o = done_q;
endmodule

// File: rtl/volt_cal_seq.sv
// volt_cal_seq: time-shared |x|*FULL_SCALE>>SHIFT scaling and BCD conversion for all ADC channels
module volt_cal_seq
  import volt_pkg::*;
(
  input  logic                     clk,
  input  logic                     ad_reset,
  input  logic                     ad_data_valid,
  input  logic [NUM_CH*DATA_W-1:0] ad_ch_all,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH*DEC_W-1:0]  ch_dec_all,
  output logic [NUM_CH*8-1:0]      ch_sig_all,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);
  state_t state_q, state_d;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH-1:0] mask_q, above;
  logic [IDX_W-1:0] idx_q;
  logic [DATA_W-1:0] mag_q, vol_q, x;
  logic [7:0] sig_q;
  logic [31:0] prod_q;
  logic [NUM_CH*DEC_W-1:0] dec_q;
  logic [NUM_CH*8-1:0] sgn_q;
  logic st_q, busy_q, busy_d, fd_q, fd_d, ov_q, ov_d, accept, last, bcd_done;
  logic [DEC_W-1:0] bcd_dec;
  assign x = data_q[idx_q*DATA_W +: DATA_W];
  // next state, frame bookkeeping and status pulses
  always_comb begin
    accept = state_q == S_IDLE && ad_data_valid;
    above = mask_q & ({{(NUM_CH-1){1'b1}}, 1'b0} << idx_q);
    last = state_q == S_STORE && above == '0;
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept && ch_en != '0 ? S_MAG : S_IDLE;
      S_MAG:   state_d = S_MUL;
      S_MUL:   state_d = S_SCALE;
      S_SCALE: state_d = S_CONV;
      S_CONV:  state_d = bcd_done ? S_STORE : S_CONV;
      S_STORE: state_d = last ? S_IDLE : S_MAG;
      default: state_d = S_IDLE;
    endcase
    busy_d = accept && ch_en != '0 ? 1'b1 : last ? 1'b0 : busy_q;
    fd_d = (accept && ch_en == '0) || last;
    ov_d = ad_data_valid && state_q != S_IDLE;
  end
  // datapath pipeline, channel walk and per-slot output banks
  always_ff @(posedge clk or posedge ad_reset)
    if (ad_reset) begin
      state_q <= S_IDLE;
      data_q <= '0;
      mask_q <= '0;
      idx_q <= '0;
      mag_q <= '0;
      sig_q <= ASCII_PLUS;
      prod_q <= '0;
      vol_q <= '0;
      st_q <= 1'b0;
      dec_q <= '0;
      sgn_q <= {NUM_CH{ASCII_PLUS}};
      busy_q <= 1'b0;
      fd_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      fd_q <= fd_d;
      ov_q <= ov_d;
      st_q <= state_q == S_SCALE;
      if (accept) begin
        data_q <= ad_ch_all;
        mask_q <= ch_en;
        idx_q <= low_idx(ch_en);
      end
      if (state_q == S_MAG) begin
        mag_q <= x[DATA_W-1] ? ~x + 1'b1 : x;
        sig_q <= x[DATA_W-1] ? ASCII_MINUS : ASCII_PLUS;
      end
      if (state_q == S_MUL) prod_q <= 32'(mag_q) * 32'(FULL_SCALE);
      if (state_q == S_SCALE) vol_q <= DATA_W'(prod_q >> SHIFT);
      if (state_q == S_STORE) begin
        dec_q[idx_q*DEC_W +: DEC_W] <= bcd_dec;
        sgn_q[idx_q*8 +: 8] <= sig_q;
        if (!last) idx_q <= low_idx(above);
      end
    end
  bcd_serial u_bcd (
    .clk(clk),
    .rst(ad_reset),
    .start_i(st_q),
    .bin_i(vol_q),
    .dec_o(bcd_dec),
    .done_o(bcd_done)
  );
  assign ch_dec_all = dec_q;
  assign ch_sig_all = sgn_q;
  assign busy = busy_q;
  assign frame_done = fd_q;
  assign overrun = ov_q;
endmodule

// File: tb/tb_volt_cal_seq.sv
// tb_volt_cal_seq: randomized self-checking bench with a behavioural per-slot reference model
module tb_volt_cal_seq;
  logic clk = 1'b0;
  logic ad_reset = 1'b1;
  logic ad_data_valid = 1'b0;
  logic [127:0] ad_ch_all = '0;
  logic [7:0] ch_en = '0;
  logic [159:0] ch_dec_all;
  logic [63:0] ch_sig_all;
  logic busy, frame_done, overrun;
  int checks = 0;
  int failures = 0;
  logic [19:0] m_dec [8];
  logic [7:0] m_sig [8];
  logic [15:0] edge_vals [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

  volt_cal_seq dut (
    .clk(clk),
    .ad_reset(ad_reset),
    .ad_data_valid(ad_data_valid),
    .ad_ch_all(ad_ch_all),
    .ch_en(ch_en),
    .ch_dec_all(ch_dec_all),
    .ch_sig_all(ch_sig_all),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int scaled(input logic [15:0] x);
    longint mag;
    mag = x[15] ? 65536 - longint'(x) : longint'(x);
    return int'(mag * 50000 / 32768);
  endfunction

  function automatic logic [127:0] rnd_frame();
    logic [127:0] r;
    for (int k = 0; k < 8; k++)
      r[16*k +: 16] = $urandom_range(0, 3) == 0 ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_dec[k] = '0;
      m_sig[k] = 8'd43;
    end
  endtask

  task automatic model_load(input logic [127:0] d, input logic [7:0] en);
    for (int k = 0; k < 8; k++)
      if (en[k]) begin
        m_dec[k] = to_bcd(scaled(d[16*k +: 16]));
        m_sig[k] = d[16*k+15] ? 8'd45 : 8'd43;
      end
  endtask

  task automatic compare_slots(input string tag);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ch_dec_all[20*k +: 20] !== m_dec[k] || ch_sig_all[8*k +: 8] !== m_sig[k]) begin
        failures++;
        $display("FAIL %s slot%0d got=%h/%0d exp=%h/%0d", tag, k, ch_dec_all[20*k +: 20], ch_sig_all[8*k +: 8], m_dec[k], m_sig[k]);
      end
    end
  endtask

  task automatic do_frame(input logic [127:0] d, input logic [7:0] en, input string tag);
    int n, c;
    n = $countones(en);
    @(negedge clk);
    ad_data_valid = 1'b1;
    ad_ch_all = d;
    ch_en = en;
    model_load(d, en);
    @(negedge clk);
    ad_data_valid = 1'b0;
    ad_ch_all = {$urandom, $urandom, $urandom, $urandom};
    ch_en = 8'($urandom);
    checks++;
    if (busy !== (n != 0)) begin
      failures++;
      $display("FAIL %s busy_start got=%0b exp=%0b", tag, busy, n != 0);
    end
    c = 1;
    while (frame_done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (frame_done !== 1'b1 || c != 1 + 22 * n) begin
      failures++;
      $display("FAIL %s frame_done_cycle got=%0d exp=%0d", tag, c, 1 + 22 * n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_end got=%0b exp=0", tag, busy);
    end
    compare_slots(tag);
  endtask

  task automatic test_reset();
    ad_reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%0b%0b%0b exp=000", busy, frame_done, overrun);
    end
    compare_slots("reset");
    ad_reset = 1'b0;
  endtask

  task automatic test_all_channels();
    logic [127:0] d;
    logic [19:0] ed [5] = '{20'h49998, 20'h50000, 20'h00001, 20'h00000, 20'h25000};
    logic [7:0] es [5] = '{8'd43, 8'd45, 8'd45, 8'd43, 8'd43};
    d = rnd_frame();
    d[79:0] = {16'h4000, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    do_frame(d, 8'hFF, "all_ch");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ch_dec_all[20*k +: 20] !== ed[k] || ch_sig_all[8*k +: 8] !== es[k]) begin
        failures++;
        $display("FAIL known_slot%0d got=%h/%0d exp=%h/%0d", k, ch_dec_all[20*k +: 20], ch_sig_all[8*k +: 8], ed[k], es[k]);
      end
    end
  endtask

  task automatic test_two_channels();
    logic [127:0] d;
    d = rnd_frame();
    d[15:0] = 16'hC000;
    d[127:112] = 16'h2000;
    do_frame(d, 8'b1000_0001, "two_ch");
    checks++;
    if (ch_dec_all[19:0] !== 20'h25000 || ch_sig_all[7:0] !== 8'd45 || ch_dec_all[159:140] !== 20'h12500 || ch_sig_all[63:56] !== 8'd43) begin
      failures++;
      $display("FAIL two_ch_known got=%h/%0d %h/%0d exp=25000/45 12500/43", ch_dec_all[19:0], ch_sig_all[7:0], ch_dec_all[159:140], ch_sig_all[63:56]);
    end
  endtask

  task automatic test_empty();
    do_frame(rnd_frame(), 8'h00, "empty");
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_after got=%0b%0b exp=00", frame_done, busy);
    end
  endtask

  task automatic test_overrun();
    logic [127:0] a, b;
    int nfd;
    a = rnd_frame();
    b = rnd_frame();
    nfd = 0;
    @(negedge clk);
    ad_data_valid = 1'b1;
    ad_ch_all = a;
    ch_en = 8'hFF;
    model_load(a, 8'hFF);
    for (int c = 1; c <= 356; c++) begin
      @(negedge clk);
      ad_data_valid = 1'b0;
      ad_ch_all = {$urandom, $urandom, $urandom, $urandom};
      ch_en = 8'($urandom);
      if (frame_done === 1'b1) nfd++;
      if (c >= 50 && c <= 52) begin
        checks++;
        if (overrun !== (c == 51)) begin
          failures++;
          $display("FAIL overrun_c%0d got=%0b exp=%0b", c, overrun, c == 51);
        end
      end
      if (c == 177 || c == 354) begin
        checks++;
        if (frame_done !== 1'b1) begin
          failures++;
          $display("FAIL ovr_frame_done_c%0d got=%0b exp=1", c, frame_done);
        end
        compare_slots(c == 177 ? "ovr_first" : "ovr_second");
      end
      if (c == 50) begin
        ad_data_valid = 1'b1;
        ch_en = 8'h0F;
      end
      if (c == 177) begin
        ad_data_valid = 1'b1;
        ad_ch_all = b;
        ch_en = 8'hFF;
        model_load(b, 8'hFF);
      end
    end
    checks++;
    if (nfd != 2) begin
      failures++;
      $display("FAIL ovr_done_count got=%0d exp=2", nfd);
    end
  endtask

  task automatic test_reset_mid();
    int nfd;
    @(negedge clk);
    ad_data_valid = 1'b1;
    ad_ch_all = rnd_frame();
    ch_en = 8'hFF;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      ad_data_valid = 1'b0;
    end
    ad_reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags got=%0b%0b%0b exp=000", busy, frame_done, overrun);
    end
    compare_slots("midreset");
    @(negedge clk);
    ad_reset = 1'b0;
    nfd = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done === 1'b1) nfd++;
    end
    checks++;
    if (nfd != 0) begin
      failures++;
      $display("FAIL midreset_stray_done got=%0d exp=0", nfd);
    end
    do_frame(rnd_frame(), 8'hFF, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] en;
    for (int f = 0; f < 200; f++) begin
      en = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) == 0 ? 8'h00 : 8'hFF) : 8'($urandom);
      do_frame(rnd_frame(), en, "random");
    end
  endtask

  initial begin
    test_reset();
    test_all_channels();
    test_two_channels();
    test_empty();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
